frame_buffer_reader: RTL
========================

Name: frame_buffer_reader

Overview:
- Read-side engine for the camera frame buffer: walks one frame of pixels out of the read port of the dual-port frame RAM while the capture side writes the other port.
- Emits the frame as a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers.
- Sits between the frame RAM read port and the downstream display/processing pipeline; accounts for the RAM's 1-cycle registered read latency and absorbs backpressure without dropping or duplicating pixels.

Parameters:
- DATA_WIDTH, 8, pixel width; must match frame RAM data width.
- ADDR_WIDTH, 8, frame RAM address width.
- H_PIXELS, 16, pixels per line, ≥1.
- V_LINES, 16, lines per frame, ≥1; BASE_ADDR + H_PIXELS*V_LINES ≤ 2**ADDR_WIDTH.
- BASE_ADDR, 0, RAM address of the first pixel of the frame.

Ports:
- clk_i  in  1  single clock, shared with frame RAM read port.
- reset_n_i  in  1  synchronous reset, active-low.
- start_i  in  1  request one frame readout; sampled only in IDLE.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse after the last pixel handshake.
- ram_addr_o  out  ADDR_WIDTH  read address to frame RAM.
- ram_en_o  out  1  read strobe; address is consumed at this edge.
- ram_data_i  in  DATA_WIDTH  RAM read data; valid the cycle after the ram_en_o edge.
- m_data_o  out  DATA_WIDTH  pixel data.
- m_valid_o  out  1  pixel valid.
- m_ready_i  in  1  downstream accept; handshake = m_valid_o & m_ready_i.
- m_sof_o  out  1  marks pixel (0,0).
- m_eol_o  out  1  marks the last pixel of each line.
- m_eof_o  out  1  marks the last pixel of the frame.

Behaviour:
- Reset (reset_n_i=0 at posedge): state=IDLE; busy_o, done_o, ram_en_o, m_valid_o, m_sof_o, m_eol_o, m_eof_o = 0; ram_addr_o = BASE_ADDR; m_data_o = 0; counters and buffer cleared. Any in-flight read is discarded.
- States:
  - IDLE: start_i=1 -> READ.
  - READ: issue reads. After the last address is issued -> DRAIN.
  - DRAIN: no further reads. After the last pixel handshake -> IDLE, with done_o=1 for that one cycle.
- start_i is ignored outside IDLE. start_i is also ignored in the cycle done_o is asserted, because the state is already IDLE only from the next cycle.
- Read issue:
  - ram_en_o=1 in READ only when (buffered entries + reads in flight) < 2.
  - The output buffer is a 2-entry FIFO; credits are counted at each edge.
  - The address increments by 1 per issued read, linearly from BASE_ADDR to BASE_ADDR+H_PIXELS*V_LINES-1.
  - No wrap beyond the frame.
- Data capture: ram_data_i is written into the FIFO in the cycle after each ram_en_o edge, together with the sof/eol/eof flags computed from the column and row counters at issue time.
- Latency: start_i=1 at edge 0 -> ram_en_o=1 during cycle 1 -> m_valid_o=1 during cycle 2 (first pixel), provided the FIFO was empty.
- Throughput: 1 pixel/cycle while m_ready_i is held high.
- Backpressure:
  - While m_valid_o=1 and m_ready_i=0, m_data_o and all flags hold stable.
  - Reads stop once the credit limit is reached; no pixel is lost or duplicated.
- Flags:
  - m_eol_o when column = H_PIXELS-1.
  - m_eof_o when column = H_PIXELS-1 and row = V_LINES-1.
  - m_sof_o only on the first pixel.
  - All flags are qualified by m_valid_o (0 when m_valid_o=0).
- Degenerate size: H_PIXELS=V_LINES=1 gives a single pixel carrying sof, eol and eof together.
- Reset mid-frame: the next state is IDLE with all outputs at reset values; a subsequent start restarts from BASE_ADDR with sof.

Test Plan:
- H_PIXELS=4, V_LINES=2, RAM preloaded with addr value, m_ready_i=1, start pulse -> 8 pixels 0x00..0x07 on consecutive cycles starting 2 cycles after start; sof on 0x00; eol on 0x03 and 0x07; eof on 0x07; done_o pulses the cycle after the 0x07 handshake; busy_o then drops.
- Same frame, m_ready_i toggling 1,0,0,1 repeating -> identical 8-pixel sequence, no duplicates or gaps; data and flags stable while stalled; ram_en_o never issues more than 2 reads ahead.
- m_ready_i=0 for 10 cycles after start -> exactly 2 reads issued (addr 0,1), m_valid_o=1 holding 0x00; on release, the stream resumes correctly.
- start_i held high throughout the frame -> one frame only; a second frame begins only after IDLE is re-entered (the cycle after done_o).
- reset_n_i=0 for one cycle after pixel 3 is accepted -> next cycle all outputs are 0 and ram_addr_o=BASE_ADDR; a new start yields 0x00 with sof.
- BASE_ADDR=0xF0, H_PIXELS=V_LINES=1 -> single read at 0xF0; one pixel with sof, eol and eof all set; done_o pulses.

Source files
------------

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader
//   Reads one frame of pixels out of the read port of the dual-port frame RAM.
//   The frame comes out as a valid/ready pixel stream with sof/eol/eof markers.
//   The RAM has a 1-cycle registered read latency. A 2-entry output FIFO plus
//   credit counting absorbs backpressure, so no pixel is dropped or repeated.
//
// Ports
//   clk_i        single clock, shared with the frame RAM read port
//   reset_n_i    synchronous reset, active-low
//   start_i      request one frame readout (sampled only in IDLE)
//   busy_o       frame in progress (includes the done cycle)
//   done_o       one-cycle pulse after the last pixel handshake
//   ram_addr_o   frame RAM read address
//   ram_en_o     frame RAM read strobe
//   ram_data_i   frame RAM read data, valid the cycle after the strobe
//   m_data_o     pixel data
//   m_valid_o    pixel valid
//   m_ready_i    downstream accept
//   m_sof_o      first pixel of the frame
//   m_eol_o      last pixel of a line
//   m_eof_o      last pixel of the frame
//
// States
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start_i
//   S_READ  | issuing reads while credits allow
//   S_DRAIN | all reads issued; flushing the stream, then one done cycle
module frame_buffer_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int H_PIXELS   = 16,
  parameter int V_LINES    = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_en_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_sof_o,
  output logic                  m_eol_o,
  output logic                  m_eof_o
);

  localparam int CW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int RW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [CW-1:0]         COL_LAST  = CW'(H_PIXELS - 1);
  localparam logic [RW-1:0]         ROW_LAST  = RW'(V_LINES - 1);
  localparam logic [CW-1:0]         COL_ONE   = CW'(1);
  localparam logic [RW-1:0]         ROW_ONE   = RW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  // flag vector layout: {sof, eol, eof}
  localparam int F_SOF = 2;
  localparam int F_EOL = 1;
  localparam int F_EOF = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_next;
  logic   done_q, done_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;

  // read issued at the last edge; its data is on ram_data_i this cycle
  logic       pend;
  logic [2:0] pend_flags;

  logic [DATA_WIDTH-1:0] fifo_data  [2];
  logic [2:0]            fifo_flags [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            fifo_count;

  logic                  start_accept, issue, last_issue, hs, push, pop;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [2:0]            head_flags, issue_flags;
  logic [1:0]            credits_used;

  // The logical queue is the FIFO followed by the in-flight RAM word. When the
  // FIFO is empty the RAM output is presented directly, which gives the first
  // pixel two cycles after start. A stalled bypassed word is pushed into the
  // FIFO, so the output stays the same while the stall lasts.
  always_comb begin
    head_valid   = (fifo_count != 2'd0) || pend;
    head_data    = ram_data_i;
    head_flags   = pend_flags;
    if (fifo_count != 2'd0) begin
      head_data  = fifo_data[rd_ptr];
      head_flags = fifo_flags[rd_ptr];
    end
    hs           = head_valid && m_ready_i;
    pop          = hs && (fifo_count != 2'd0);
    push         = pend && !(hs && (fifo_count == 2'd0));
    credits_used = fifo_count + {1'b0, pend};
    issue        = (state == S_READ) && (credits_used < 2'd2);
    last_issue   = issue && (col == COL_LAST) && (row == ROW_LAST);
    start_accept = (state == S_IDLE) && start_i;
    issue_flags[F_SOF] = (col == '0) && (row == '0);
    issue_flags[F_EOL] = (col == COL_LAST);
    issue_flags[F_EOF] = (col == COL_LAST) && (row == ROW_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
    end
  end

  // DRAIN lasts one more cycle after the eof handshake. That extra cycle is
  // the done cycle, and start_i is ignored in it.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) state_next = S_READ;
      end
      S_READ: begin
        if (last_issue) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (done_q) state_next = S_IDLE;
        else if (hs && head_flags[F_EOF]) done_next = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      addr       <= ADDR_BASE;
      col        <= '0;
      row        <= '0;
      pend       <= 1'b0;
      pend_flags <= '0;
      fifo_count <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i]  <= '0;
        fifo_flags[i] <= '0;
      end
    end else begin
      if (start_accept) begin
        addr <= ADDR_BASE;
        col  <= '0;
        row  <= '0;
      end else if (issue && !last_issue) begin
        // the address stays on the last pixel, so it never runs past the frame
        addr <= addr + ADDR_ONE;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_ONE;
        end else begin
          col <= col + COL_ONE;
        end
      end

      pend <= issue;
      if (issue) pend_flags <= issue_flags;

      if (push) begin
        fifo_data[wr_ptr]  <= ram_data_i;
        fifo_flags[wr_ptr] <= pend_flags;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign busy_o     = (state != S_IDLE);
  assign done_o     = done_q;
  assign ram_en_o   = issue;
  assign ram_addr_o = addr;
  assign m_valid_o  = head_valid;
  assign m_data_o   = head_valid ? head_data : '0;
  assign m_sof_o    = head_valid && head_flags[F_SOF];
  assign m_eol_o    = head_valid && head_flags[F_EOL];
  assign m_eof_o    = head_valid && head_flags[F_EOF];

endmodule
